// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants, port index and lock-state types
package router_pkg;

  localparam int NPORT     = 5;
  localparam int BUF_DEPTH = 4;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-wide round-robin picker; searches ptr+1, ptr+2, ... modulo N
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output round-robin switch allocator with wormhole lock and credits
// Optional per-output grant/stall counters: SWITCH_ALLOC_PERF_CNT_EN
module switch_allocator #(
  parameter int NPORT     = router_pkg::NPORT,
  parameter int BUF_DEPTH = router_pkg::BUF_DEPTH,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORT-1:0]     req_valid_i,
  input  logic [3*NPORT-1:0]   req_port_i,
  input  logic [NPORT-1:0]     req_tail_i,
  input  logic [NPORT-1:0]     credit_incr_i,
  output logic [NPORT-1:0]     grant_o,
  output logic [NPORT-1:0]     out_valid_o,
  output logic [3*NPORT-1:0]   out_sel_o,
  output logic                 credit_err_o
`ifdef SWITCH_ALLOC_PERF_CNT_EN
  ,
  output logic [16*NPORT-1:0]  perf_grant_o,
  output logic [16*NPORT-1:0]  perf_stall_o
`endif
);

  import router_pkg::*;

  logic [CW-1:0]    credit     [NPORT];
  logic [2:0]       rr_ptr     [NPORT];
  lock_e            lock_state [NPORT];
  logic [2:0]       owner      [NPORT];
  logic [NPORT-1:0] route      [NPORT];
  logic [NPORT-1:0] elig       [NPORT];
  logic [NPORT-1:0] gnt        [NPORT];
  logic [2:0]       gnt_idx    [NPORT];
  logic [NPORT-1:0] gnt_any;
  logic [NPORT-1:0] grant_raw;
  logic             bad_req;
  logic             overflow;

  // route[o][i]: input i wants output o regardless of credit or lock
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        route[o][i] = req_valid_i[i] && (req_port_i[3*i +: 3] == 3'(o));
        elig[o][i]  = route[o][i] && (credit[o] != '0) &&
                      ((lock_state[o] == IDLE) || (owner[o] == 3'(i)));
      end
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    rr_arbiter #(.N(NPORT), .PW(3)) u_arb (
      .req (elig[o]),
      .ptr (rr_ptr[o]),
      .gnt (gnt[o])
    );
  end

  always_comb begin
    grant_raw = '0;
    bad_req   = 1'b0;
    overflow  = 1'b0;
    for (int o = 0; o < NPORT; o++) begin
      gnt_any[o] = |gnt[o];
      gnt_idx[o] = '0;
      for (int i = 0; i < NPORT; i++) begin
        if (gnt[o][i]) gnt_idx[o] = 3'(i);
        grant_raw[i] = grant_raw[i] | gnt[o][i];
      end
      if (credit_incr_i[o] && !gnt_any[o] && (credit[o] == CW'(BUF_DEPTH)))
        overflow = 1'b1;
    end
    for (int i = 0; i < NPORT; i++) begin
      if (req_valid_i[i] && (req_port_i[3*i +: 3] > LOCAL)) bad_req = 1'b1;
    end
  end

  assign grant_o = rst ? grant_raw : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NPORT; o++) begin
        credit[o]     <= CW'(BUF_DEPTH);
        rr_ptr[o]     <= 3'(NPORT - 1);
        lock_state[o] <= IDLE;
        owner[o]      <= '0;
      end
      out_valid_o  <= '0;
      out_sel_o    <= '0;
      credit_err_o <= 1'b0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        out_valid_o[o] <= gnt_any[o];
        if (gnt_any[o]) begin
          rr_ptr[o]         <= gnt_idx[o];
          out_sel_o[3*o +: 3] <= gnt_idx[o];
          if (lock_state[o] == IDLE && !req_tail_i[gnt_idx[o]]) begin
            lock_state[o] <= LOCKED;
            owner[o]      <= gnt_idx[o];
          end else if (lock_state[o] == LOCKED && req_tail_i[gnt_idx[o]]) begin
            lock_state[o] <= IDLE;
          end
          if (!credit_incr_i[o]) credit[o] <= credit[o] - 1'b1;
        end else if (credit_incr_i[o] && credit[o] != CW'(BUF_DEPTH)) begin
          credit[o] <= credit[o] + 1'b1;
        end
      end
      if (overflow || bad_req) credit_err_o <= 1'b1;
    end
  end

`ifdef SWITCH_ALLOC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_grant_o <= '0;
      perf_stall_o <= '0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (gnt_any[o] && perf_grant_o[16*o +: 16] != 16'hFFFF)
          perf_grant_o[16*o +: 16] <= perf_grant_o[16*o +: 16] + 16'd1;
        if ((|route[o]) && credit[o] == '0 && perf_stall_o[16*o +: 16] != 16'hFFFF)
          perf_stall_o[16*o +: 16] <= perf_stall_o[16*o +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Sequential switch allocator for the 5-port wormhole router: shares each output port among the five input buffers and sequences crossbar traversal.
- Per output: round-robin arbitration, packet lock from head flit to tail flit, and a downstream credit counter.
- Grants pop the input buffers. Registered route selects and valids drive the crossbar and the downstream valid lines.

Parameters:
- NPORT, 5, number of router ports. Fixed index order: 0 north, 1 south, 2 east, 3 west, 4 local.
- BUF_DEPTH, 4, downstream input-buffer depth in flits; initial credit per output.
- CW, $clog2(BUF_DEPTH+1), credit counter width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NPORT  input i has a head-of-queue flit requesting an output.
- req_port_i  in  3*NPORT  requested output index for input i (bits 3i+2:3i); values 5-7 are invalid.
- req_tail_i  in  NPORT  flit at head of input i is a tail flit (single-flit packet: head and tail together).
- credit_incr_i  in  NPORT  downstream buffer behind output o freed one slot.
- grant_o  out  NPORT  combinational pop strobe for input i; at most one per input.
- out_valid_o  out  NPORT  registered; output o carries a flit this cycle.
- out_sel_o  out  3*NPORT  registered; input index routed to output o.
- credit_err_o  out  1  sticky; credit overflow or invalid port request seen.

Behaviour:
- Reset (rst low, async):
  - credit[o] = BUF_DEPTH, rr_ptr[o] = NPORT-1, lock_state[o] = IDLE, owner[o] = 0.
  - out_valid_o = 0, out_sel_o = 0, credit_err_o = 0.
  - grant_o = 0 while rst is low.
- Eligibility: input i is eligible for output o when req_valid_i[i] and req_port_i[i] == o and credit[o] > 0.
  - In LOCKED state, only owner[o] is eligible.
- Arbitration: in IDLE, output o grants the first eligible input searching rr_ptr[o]+1, +2, ... modulo NPORT.
  - At most one grant per output. Each input requests one output, so no input-side conflict exists.
- grant_o is combinational from registered state and current requests. The buffer pops at that clock edge, and req_* in the next cycle reflects the next flit.
  - Sustained throughput: 1 flit/cycle per output.
- On a grant of input i to output o, at the clock edge:
  - rr_ptr[o] <= i.
  - out_valid_o[o] <= 1 and out_sel_o[o] <= i, i.e. one-cycle latency from grant to crossbar valid.
  - credit[o] decrements.
- Lock FSM per output:
  - IDLE -> LOCKED on a granted flit with req_tail_i = 0; owner <= i.
  - LOCKED -> IDLE on a granted flit from the owner with req_tail_i = 1.
  - A tail granted in IDLE stays IDLE.
- Stalls: a LOCKED output stalls (no grant, out_valid 0) if the owner is not requesting or credit is 0. Other inputs wait.
- Credit update:
  - Simultaneous grant and credit_incr_i leaves the count unchanged.
  - credit_incr_i at credit == BUF_DEPTH with no grant saturates and sets credit_err_o.
- Invalid port: req_valid_i with req_port_i > 4 is never granted and sets credit_err_o.
- No grant: out_valid_o[o] <= 0 and out_sel_o[o] holds its value.
- Reset mid-packet: all locks are released and credits are restored. Upstream buffers are reset by the same rst.

Optional Feature:
- Macro: SWITCH_ALLOC_PERF_CNT_EN.
- Defined:
  - Adds output port perf_grant_o (16*NPORT): per-output saturating grant counters.
  - Adds output port perf_stall_o (16*NPORT): per-output saturating counters of cycles with an eligible-by-route requester but zero credit.
  - Both counters reset to 0.
- Undefined: neither port nor any counter logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package router_pkg:
  - Port index typedef (3-bit enum: NORTH, SOUTH, EAST, WEST, LOCAL).
  - NPORT and BUF_DEPTH constants.
  - Lock-state enum {IDLE, LOCKED}.
- One sub-module, rr_arbiter: NPORT-wide round-robin picker. Inputs: request vector and pointer. Output: one-hot grant. Instantiated once per output.

Test Plan:
- Reset, then input 0 (north) requests output 2, single-flit (tail=1) -> grant_o=00001 same cycle; next cycle out_valid_o[2]=1, out_sel_o[2]=0, credit[2]=3.
- Inputs 0, 1 and 3 request output 4 with tails held every cycle -> grants rotate 0, 1, 3, 0, ...; no input granted twice before the others.
- Input 1 sends a 3-flit packet to output 0 while input 2 also requests output 0 -> input 2 is blocked until input 1's tail is granted, then input 2 is granted the next cycle.
- Output 3 with no credit_incr: 4 back-to-back grants, then credit=0 -> grant stops and out_valid_o[3]=0. One credit_incr_i[3] -> exactly one more grant.
- credit_incr_i[1] at full credit -> credit stays 4 and credit_err_o=1 (sticky). Separately, req_port_i=6 -> no grant and credit_err_o=1.
- Assert rst mid-packet (output 2 LOCKED, credit 1) -> immediately out_valid_o=0 and grant_o=0; after release, credit=4, IDLE, and a new requester is granted.
